// File: rtl/sdram_chip_model.sv
`default_nettype none
// ============================================================================
// Module   : sdram_chip_model
// Purpose  : Chip-side responder for a 16-bit single-rank SDRAM command bus.
//            Decodes commands, tracks open rows per bank, returns read data
//            after the programmed CAS latency, applies DQM byte masks on
//            writes and raises sticky flags on controller protocol errors.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_chip_model #(
    parameter int ROW_BITS = 3,
    parameter int COL_BITS = 6,
    parameter int TRCD     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sdram_ncs,
    input  logic        sdram_cke,
    input  logic        sdram_nras,
    input  logic        sdram_ncas,
    input  logic        sdram_nwe,
    input  logic [1:0]  sdram_ba,
    input  logic [12:0] sdram_a,
    input  logic        sdram_dqml,
    input  logic        sdram_dqmh,
    input  logic [15:0] sdram_dq_i,
    output logic [15:0] sdram_dq_o,
    output logic [1:0]  sdram_dq_oe,
    output logic [12:0] mode_reg,
    output logic        mode_valid,
    output logic [15:0] refresh_count,
    output logic [7:0]  err
);
    // Word index is {bank, kept row bits, kept column bits}; upper address
    // bits alias onto the same words.
    localparam int IDX_W = 2 + ROW_BITS + COL_BITS;
    localparam int DEPTH = 1 << IDX_W;
    localparam int CNT_W = $clog2(TRCD + 1);
    localparam logic [CNT_W-1:0] c_trcd    = CNT_W'(TRCD);
    localparam logic [CNT_W-1:0] c_trcd_m1 = CNT_W'(TRCD - 1);

    localparam logic [2:0] c_cmd_nop = 3'b111;
    localparam logic [2:0] c_cmd_act = 3'b011;
    localparam logic [2:0] c_cmd_rd  = 3'b101;
    localparam logic [2:0] c_cmd_wr  = 3'b100;
    localparam logic [2:0] c_cmd_pre = 3'b010;
    localparam logic [2:0] c_cmd_ref = 3'b001;
    localparam logic [2:0] c_cmd_lmr = 3'b000;

    logic [7:0]          r_mem_lo [DEPTH];
    logic [7:0]          r_mem_hi [DEPTH];
    logic [3:0]          r_open;
    logic [ROW_BITS-1:0] r_row [4];
    logic [CNT_W-1:0]    r_cnt [4];
    logic [12:0]         r_mode;
    logic                r_mode_valid;
    logic                r_cl3;
    logic [15:0]         r_refresh;
    logic [6:0]          r_err;
    // Read pipeline: slot 0 drives the bus on the next edge; CL=2 enters at
    // slot 1 and CL=3 at slot 2 so each entry keeps the CL it was issued with.
    logic [2:0]          r_pv;
    logic [15:0]         r_pd [3];
    logic [1:0]          r_pm [3];
    logic [15:0]         r_dq_o;
    logic [1:0]          r_dq_oe;

    logic [2:0]          w_cmd;
    logic                w_is_act;
    logic                w_is_rd;
    logic                w_is_wr;
    logic                w_is_pre;
    logic                w_is_ref;
    logic                w_is_lmr;
    logic                w_acc;
    logic [IDX_W-1:0]    w_idx;
    logic [15:0]         w_rdata;
    logic [6:0]          w_err_set;

    assign w_cmd    = (!sdram_ncs && sdram_cke) ? {sdram_nras, sdram_ncas, sdram_nwe} : c_cmd_nop;
    assign w_is_act = (w_cmd == c_cmd_act);
    assign w_is_rd  = (w_cmd == c_cmd_rd);
    assign w_is_wr  = (w_cmd == c_cmd_wr);
    assign w_is_pre = (w_cmd == c_cmd_pre);
    assign w_is_ref = (w_cmd == c_cmd_ref);
    assign w_is_lmr = (w_cmd == c_cmd_lmr);
    assign w_acc    = w_is_rd || w_is_wr;
    assign w_idx    = {sdram_ba, r_row[sdram_ba], sdram_a[COL_BITS-1:0]};
    assign w_rdata  = {r_mem_hi[w_idx], r_mem_lo[w_idx]};

    // Violation detection for the command on the bus this cycle
    always_comb begin
        w_err_set    = '0;
        w_err_set[0] = w_acc && (r_cnt[sdram_ba] < c_trcd_m1);
        w_err_set[1] = w_acc && !r_open[sdram_ba];
        w_err_set[2] = w_is_act && r_open[sdram_ba];
        w_err_set[3] = (w_is_ref || w_is_lmr) && (|r_open);
        w_err_set[4] = w_is_lmr && (((sdram_a[6:4] != 3'd2) && (sdram_a[6:4] != 3'd3)) ||
                                    (sdram_a[2:0] != 3'd0));
        w_err_set[5] = w_acc && !r_mode_valid;
        w_err_set[6] = w_is_wr && (|r_pv);
    end

    // Byte-masked array writes; contents intentionally survive reset
    always_ff @(posedge clk) begin
        if (w_is_wr) begin
            if (!sdram_dqml) r_mem_lo[w_idx] <= sdram_dq_i[7:0];
            if (!sdram_dqmh) r_mem_hi[w_idx] <= sdram_dq_i[15:8];
        end
    end

    // Per-bank open flag, row address and ACTIVE-to-access counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_open <= '0;
            for (int b = 0; b < 4; b++) begin
                r_row[b] <= '0;
                r_cnt[b] <= c_trcd;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (r_cnt[b] != c_trcd) r_cnt[b] <= r_cnt[b] + CNT_W'(1);
            end
            if (w_is_act) begin
                r_row[sdram_ba]  <= sdram_a[ROW_BITS-1:0];
                r_open[sdram_ba] <= 1'b1;
                r_cnt[sdram_ba]  <= '0;
            end
            if (w_acc && sdram_a[10]) r_open[sdram_ba] <= 1'b0;
            if (w_is_pre) begin
                if (sdram_a[10]) r_open <= '0;
                else             r_open[sdram_ba] <= 1'b0;
            end
        end
    end

    // Mode register, refresh counter and sticky error flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode       <= '0;
            r_mode_valid <= 1'b0;
            r_cl3        <= 1'b0;
            r_refresh    <= '0;
            r_err        <= '0;
        end else begin
            if (w_is_lmr) begin
                r_mode       <= sdram_a;
                r_mode_valid <= 1'b1;
                r_cl3        <= (sdram_a[6:4] == 3'd3);
            end
            if (w_is_ref) r_refresh <= r_refresh + 16'd1;
            r_err <= r_err | w_err_set;
        end
    end

    // Read data pipeline and one-cycle output drive
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pv    <= '0;
            r_dq_o  <= '0;
            r_dq_oe <= '0;
            for (int s = 0; s < 3; s++) begin
                r_pd[s] <= '0;
                r_pm[s] <= '0;
            end
        end else begin
            r_pv[0] <= r_pv[1];
            r_pd[0] <= r_pd[1];
            r_pm[0] <= r_pm[1];
            r_pv[1] <= r_pv[2];
            r_pd[1] <= r_pd[2];
            r_pm[1] <= r_pm[2];
            r_pv[2] <= 1'b0;
            if (w_is_rd) begin
                if (r_cl3) begin
                    r_pv[2] <= 1'b1;
                    r_pd[2] <= w_rdata;
                    r_pm[2] <= {sdram_dqmh, sdram_dqml};
                end else begin
                    r_pv[1] <= 1'b1;
                    r_pd[1] <= w_rdata;
                    r_pm[1] <= {sdram_dqmh, sdram_dqml};
                end
            end
            r_dq_oe <= r_pv[0] ? ~r_pm[0] : 2'b00;
            r_dq_o  <= r_pv[0] ? r_pd[0] : 16'h0000;
        end
    end

    assign sdram_dq_o    = r_dq_o;
    assign sdram_dq_oe   = r_dq_oe;
    assign mode_reg      = r_mode;
    assign mode_valid    = r_mode_valid;
    assign refresh_count = r_refresh;
    assign err           = {1'b0, r_err};

endmodule
`default_nettype wire

// File: tb/tb_sdram_chip_model.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_chip_model
// Purpose  : Self-checking bench for sdram_chip_model: directed bring-up
//            sequence followed by randomized commands against a word-level
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_chip_model;
    localparam int ROW_BITS = 3;
    localparam int COL_BITS = 6;
    localparam int TRCD     = 2;

    localparam logic [2:0] C_NOP = 3'b111;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_BST = 3'b110;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_LMR = 3'b000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sdram_ncs = 1'b1;
    logic        sdram_cke = 1'b1;
    logic        sdram_nras = 1'b1;
    logic        sdram_ncas = 1'b1;
    logic        sdram_nwe = 1'b1;
    logic [1:0]  sdram_ba = '0;
    logic [12:0] sdram_a = '0;
    logic        sdram_dqml = 1'b0;
    logic        sdram_dqmh = 1'b0;
    logic [15:0] sdram_dq_i = '0;
    logic [15:0] sdram_dq_o;
    logic [1:0]  sdram_dq_oe;
    logic [12:0] mode_reg;
    logic        mode_valid;
    logic [15:0] refresh_count;
    logic [7:0]  err;

    always #5 clk = ~clk;

    sdram_chip_model #(.ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .TRCD(TRCD)) dut (
        .clk(clk), .reset(reset), .sdram_ncs(sdram_ncs), .sdram_cke(sdram_cke),
        .sdram_nras(sdram_nras), .sdram_ncas(sdram_ncas), .sdram_nwe(sdram_nwe),
        .sdram_ba(sdram_ba), .sdram_a(sdram_a), .sdram_dqml(sdram_dqml),
        .sdram_dqmh(sdram_dqmh), .sdram_dq_i(sdram_dq_i), .sdram_dq_o(sdram_dq_o),
        .sdram_dq_oe(sdram_dq_oe), .mode_reg(mode_reg), .mode_valid(mode_valid),
        .refresh_count(refresh_count), .err(err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic [15:0] data;
        logic [1:0]  oe;
        bit          known;
    } rd_t;

    int          edge_n = 0;
    bit          m_open [4];
    int          m_row [4];
    int          m_last_act [4];
    logic [12:0] m_mode;
    bit          m_mode_valid;
    int          m_cl;
    logic [15:0] m_ref;
    logic [7:0]  m_err;
    logic [7:0]  m_lo [int];
    logic [7:0]  m_hi [int];
    rd_t         m_q [$];
    logic [1:0]  exp_oe;
    logic [15:0] exp_do;
    bit          exp_known;

    task automatic model_reset();
        for (int b = 0; b < 4; b++) begin
            m_open[b]     = 1'b0;
            m_row[b]      = -1;
            m_last_act[b] = -1000;
        end
        m_mode = '0; m_mode_valid = 1'b0; m_cl = 2; m_ref = '0; m_err = '0;
        m_q.delete();
    endtask

    function automatic bit any_open();
        return m_open[0] | m_open[1] | m_open[2] | m_open[3];
    endfunction

    task automatic model_edge(input bit rst_v, input bit ncs, input bit cke, input logic [2:0] cmd_in,
                              input logic [1:0] ba, input logic [12:0] a, input logic [1:0] dqm,
                              input logic [15:0] dq);
        logic [2:0] c;
        int idx;
        bit pend;
        rd_t e;
        exp_oe = 2'b00; exp_do = '0; exp_known = 1'b0;
        if (rst_v) begin
            model_reset();
            return;
        end
        c = (ncs || !cke) ? C_NOP : cmd_in;
        case (c)
            C_ACT: begin
                if (m_open[ba]) m_err[2] = 1'b1;
                m_row[ba] = int'(a) % (1 << ROW_BITS);
                m_open[ba] = 1'b1;
                m_last_act[ba] = edge_n;
            end
            C_RD, C_WR: begin
                if (!m_open[ba]) m_err[1] = 1'b1;
                if (edge_n - m_last_act[ba] < TRCD) m_err[0] = 1'b1;
                if (!m_mode_valid) m_err[5] = 1'b1;
                idx = int'(ba) * (1 << (ROW_BITS + COL_BITS)) + m_row[ba] * (1 << COL_BITS) +
                      int'(a) % (1 << COL_BITS);
                if (c == C_WR) begin
                    pend = 1'b0;
                    foreach (m_q[i]) if (m_q[i].due >= edge_n) pend = 1'b1;
                    if (pend) m_err[6] = 1'b1;
                    if (m_row[ba] >= 0) begin
                        if (!dqm[0]) m_lo[idx] = dq[7:0];
                        if (!dqm[1]) m_hi[idx] = dq[15:8];
                    end
                end else begin
                    e.due   = edge_n + m_cl;
                    e.oe    = ~dqm;
                    e.known = (m_row[ba] >= 0) && m_lo.exists(idx) && m_hi.exists(idx);
                    e.data  = e.known ? {m_hi[idx], m_lo[idx]} : 16'h0000;
                    m_q.push_back(e);
                end
                if (a[10]) m_open[ba] = 1'b0;
            end
            C_PRE: begin
                if (a[10]) for (int b = 0; b < 4; b++) m_open[b] = 1'b0;
                else m_open[ba] = 1'b0;
            end
            C_REF: begin
                m_ref = m_ref + 16'd1;
                if (any_open()) m_err[3] = 1'b1;
            end
            C_LMR: begin
                if (any_open()) m_err[3] = 1'b1;
                m_mode = a; m_mode_valid = 1'b1;
                if (a[6:4] == 3'd3) m_cl = 3;
                else begin
                    m_cl = 2;
                    if (a[6:4] != 3'd2) m_err[4] = 1'b1;
                end
                if (a[2:0] != 3'd0) m_err[4] = 1'b1;
            end
            default: ;
        endcase
        foreach (m_q[i]) if (m_q[i].due == edge_n) begin
            exp_oe = m_q[i].oe; exp_do = m_q[i].data; exp_known = m_q[i].known;
        end
        for (int i = m_q.size() - 1; i >= 0; i--) if (m_q[i].due <= edge_n) m_q.delete(i);
    endtask

    // One clock: drive at negedge, model the rising edge, sample just after it
    task automatic cycle(input bit rst_v, input bit ncs, input bit cke, input logic [2:0] c,
                         input logic [1:0] ba, input logic [12:0] a, input logic [1:0] dqm,
                         input logic [15:0] dq);
        @(negedge clk);
        reset = rst_v; sdram_ncs = ncs; sdram_cke = cke;
        {sdram_nras, sdram_ncas, sdram_nwe} = c;
        sdram_ba = ba; sdram_a = a; {sdram_dqmh, sdram_dqml} = dqm; sdram_dq_i = dq;
        @(posedge clk);
        edge_n++;
        model_edge(rst_v, ncs, cke, c, ba, a, dqm, dq);
        #1;
        check_val("dq_oe", 32'(sdram_dq_oe), 32'(exp_oe));
        if (exp_oe != 2'b00 && exp_known) check_val("dq_o", 32'(sdram_dq_o), 32'(exp_do));
        check_val("err", 32'(err), 32'(m_err));
        check_val("refresh_count", 32'(refresh_count), 32'(m_ref));
        check_val("mode_reg", 32'(mode_reg), 32'(m_mode));
        check_val("mode_valid", 32'(mode_valid), 32'(m_mode_valid));
    endtask

    task automatic cmd(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] a,
                       input logic [1:0] dqm, input logic [15:0] dq);
        cycle(1'b0, 1'b0, 1'b1, c, ba, a, dqm, dq);
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) cmd(C_NOP, 2'd0, 13'd0, 2'b00, 16'h0);
    endtask

    task automatic rd(input logic [1:0] ba, input int col, input bit ap, input logic [1:0] dqm);
        cmd(C_RD, ba, 13'(col) | (ap ? 13'h400 : 13'h0), dqm, 16'h0);
    endtask

    task automatic wr(input logic [1:0] ba, input int col, input logic [1:0] dqm, input logic [15:0] dq);
        cmd(C_WR, ba, 13'(col), dqm, dq);
    endtask

    task automatic init_seq(input logic [12:0] mode);
        cmd(C_PRE, 2'd0, 13'h400, 2'b00, 16'h0);
        for (int i = 0; i < 8; i++) cmd(C_REF, 2'd0, 13'h0, 2'b00, 16'h0);
        cmd(C_LMR, 2'd0, mode, 2'b00, 16'h0);
    endtask

    initial begin
        logic [2:0]  rc;
        logic [12:0] ra;
        int          r;
        model_reset();
        // reset state
        cycle(1'b1, 1'b1, 1'b1, C_NOP, 2'd0, 13'h0, 2'b00, 16'h0);
        cycle(1'b1, 1'b1, 1'b1, C_NOP, 2'd0, 13'h0, 2'b00, 16'h0);
        check_val("rst_dq_o", 32'(sdram_dq_o), 32'h0);
        nop(1);

        // bring-up
        init_seq(13'h220);
        check_val("init_mode_reg", 32'(mode_reg), 32'h220);
        check_val("init_refresh", 32'(refresh_count), 32'd8);
        check_val("init_err", 32'(err), 32'h0);

        // write then read back, CL=2
        cmd(C_ACT, 2'd1, 13'd5, 2'b00, 16'h0);
        nop(1);
        wr(2'd1, 3, 2'b00, 16'hA55A);
        rd(2'd1, 3, 1'b0, 2'b00);
        nop(1);
        check_val("cl2_not_early", 32'(sdram_dq_oe), 32'h0);
        nop(1);
        check_val("cl2_oe", 32'(sdram_dq_oe), 32'h3);
        check_val("cl2_data", 32'(sdram_dq_o), 32'hA55A);
        nop(1);
        check_val("cl2_oe_drop", 32'(sdram_dq_oe), 32'h0);
        check_val("rw_err", 32'(err), 32'h0);

        // high byte masked write, low byte masked read
        wr(2'd1, 3, 2'b10, 16'h1234);
        rd(2'd1, 3, 1'b0, 2'b00);
        nop(3);
        rd(2'd1, 3, 1'b0, 2'b01);
        nop(3);

        // tRCD violation then refresh with a bank open
        cmd(C_ACT, 2'd2, 13'd1, 2'b00, 16'h0);
        rd(2'd2, 0, 1'b0, 2'b00);
        check_val("trcd_err0", 32'(err[0]), 32'h1);
        nop(3);
        cmd(C_REF, 2'd0, 13'h0, 2'b00, 16'h0);
        check_val("ref_open_err3", 32'(err[3]), 32'h1);
        check_val("ref_count", 32'(refresh_count), 32'd9);

        // auto-precharge, then access to a closed bank, then CL=3
        rd(2'd1, 3, 1'b1, 2'b00);
        nop(3);
        rd(2'd1, 3, 1'b0, 2'b00);
        check_val("closed_err1", 32'(err[1]), 32'h1);
        nop(3);
        cmd(C_LMR, 2'd0, 13'h230, 2'b00, 16'h0);
        rd(2'd1, 3, 1'b0, 2'b00);
        nop(2);
        check_val("cl3_not_early", 32'(sdram_dq_oe), 32'h0);
        nop(1);
        check_val("cl3_data", 32'(sdram_dq_o), 32'hA534);
        nop(2);

        // reset one clock after a READ flushes it
        rd(2'd1, 3, 1'b0, 2'b00);
        nop(1);
        cycle(1'b1, 1'b1, 1'b1, C_NOP, 2'd0, 13'h0, 2'b00, 16'h0);
        cycle(1'b1, 1'b1, 1'b1, C_NOP, 2'd0, 13'h0, 2'b00, 16'h0);
        cycle(1'b1, 1'b1, 1'b1, C_NOP, 2'd0, 13'h0, 2'b00, 16'h0);
        check_val("rst_err", 32'(err), 32'h0);
        check_val("rst_mode_valid", 32'(mode_valid), 32'h0);
        nop(1);
        init_seq(13'h220);
        cmd(C_ACT, 2'd1, 13'd5, 2'b00, 16'h0);
        nop(1);
        rd(2'd1, 3, 1'b0, 2'b00);
        nop(2);
        check_val("persist_data", 32'(sdram_dq_o), 32'hA534);
        nop(2);

        // randomized traffic, every bank given a known row first
        cmd(C_PRE, 2'd0, 13'h400, 2'b00, 16'h0);
        for (int b = 0; b < 4; b++) cmd(C_ACT, 2'(b), 13'($urandom), 2'b00, 16'h0);
        nop(2);
        cmd(C_PRE, 2'd0, 13'h400, 2'b00, 16'h0);
        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 99);
            if      (r < 20) rc = C_ACT;
            else if (r < 45) rc = C_RD;
            else if (r < 70) rc = C_WR;
            else if (r < 80) rc = C_NOP;
            else if (r < 84) rc = C_BST;
            else if (r < 92) rc = C_PRE;
            else if (r < 96) rc = C_REF;
            else             rc = C_LMR;
            ra = 13'($urandom);
            if (rc == C_LMR) begin
                r = $urandom_range(0, 3);
                if (r == 0)      ra = 13'h220;
                else if (r == 1) ra = 13'h230;
            end
            cycle(1'b0, ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) != 0), rc,
                  2'($urandom_range(0, 3)), ra,
                  ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00,
                  16'($urandom));
        end
        nop(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
